// File: rtl/queued_direction_controller_pkg.sv
// utils: shared direction type and direction helpers for sprite control
package utils;
  typedef enum logic [2:0] {IDLE, UP, RIGHT, DOWN, LEFT} direction_t;

  function automatic direction_t opposite(input direction_t d);
    return d == UP ? DOWN : d == DOWN ? UP : d == RIGHT ? LEFT : d == LEFT ? RIGHT : IDLE;
  endfunction

  function automatic logic [1:0] dir_index(input direction_t d);
    return d == RIGHT ? 2'd1 : d == DOWN ? 2'd2 : d == LEFT ? 2'd3 : 2'd0;
  endfunction
endpackage

// File: rtl/queued_direction_controller_debouncer.sv
// button_debouncer: stable-level filter with a one-cycle registered press pulse
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
  logic flip;
  assign flip = raw != level && cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
  // count consecutive disagreeing samples; flip the level once enough have been seen
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      level <= 1'b0;
      rise <= 1'b0;
    end else begin
      rise <= flip && raw;
      cnt <= (raw == level || flip) ? '0 : cnt + 1'b1;
      level <= flip ? raw : level;
    end
endmodule

// File: rtl/queued_direction_controller.sv
// queued_direction_controller: debounced, prioritised, tile-aligned direction control
module queued_direction_controller
  import utils::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PENDING_TIMEOUT = 3,
  parameter int REVERSE_IMMEDIATE = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       restart,
  input  logic       up,
  input  logic       right,
  input  logic       down,
  input  logic       left,
  input  logic       tile_aligned,
  input  logic [3:0] wall_free,
  output direction_t dir,
  output direction_t pending_dir,
  output logic       pending_valid,
  output logic       turn_strobe
);
  localparam int TW = PENDING_TIMEOUT > 0 ? $clog2(PENDING_TIMEOUT + 1) : 1;
  logic [3:0] raw, level, rise, pulse;
  logic [TW-1:0] timer;
  direction_t p, cand;
  logic eff, imm, take, blocked;
  assign raw = {left, down, right, up};
  assign pulse = rise & level;
  for (genvar i = 0; i < 4; i++) begin : g_db
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk), .reset_n(reset_n), .raw(raw[i]), .level(level[i]), .rise(rise[i])
    );
  end
  // fixed-priority winner among simultaneous presses and the resulting decisions
  always_comb begin
    p = pulse[2] ? DOWN : pulse[0] ? UP : pulse[3] ? LEFT : pulse[1] ? RIGHT : IDLE;
    eff = p != IDLE && !(dir != IDLE && p == dir);
    imm = eff && ((REVERSE_IMMEDIATE != 0 && dir != IDLE && p == opposite(dir)) ||
                  (dir == IDLE && wall_free[dir_index(p)]));
    cand = eff ? p : (pending_valid ? pending_dir : IDLE);
    take = cand != IDLE && wall_free[dir_index(cand)];
    blocked = dir != IDLE && !wall_free[dir_index(dir)];
  end
  // direction register, pending request and its expiry timer
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      dir <= IDLE;
      pending_dir <= IDLE;
      pending_valid <= 1'b0;
      timer <= '0;
      turn_strobe <= 1'b0;
    end else if (restart) begin
      dir <= IDLE;
      pending_dir <= IDLE;
      pending_valid <= 1'b0;
      timer <= '0;
      turn_strobe <= 1'b0;
    end else begin
      turn_strobe <= 1'b0;
      if (imm) begin
        dir <= p;
        turn_strobe <= 1'b1;
        pending_dir <= IDLE;
        pending_valid <= 1'b0;
        timer <= '0;
      end else if (tile_aligned && take) begin
        dir <= cand;
        turn_strobe <= cand != dir;
        pending_dir <= IDLE;
        pending_valid <= 1'b0;
        timer <= '0;
      end else if (eff) begin
        pending_dir <= p;
        pending_valid <= 1'b1;
        timer <= TW'(PENDING_TIMEOUT);
        if (tile_aligned && blocked) dir <= IDLE;
      end else if (tile_aligned) begin
        if (blocked) dir <= IDLE;
        if (pending_valid && PENDING_TIMEOUT != 0) begin
          timer <= timer - 1'b1;
          if (timer == TW'(1)) begin
            pending_valid <= 1'b0;
            pending_dir <= IDLE;
          end
        end
      end
    end
endmodule

// File: tb/tb_queued_direction_controller.sv
// tb_queued_direction_controller: directed, table-driven and randomized checks
module tb_queued_direction_controller;
  import utils::*;
  localparam int DEB = 4;
  localparam int TMO = 3;

  logic clk = 1'b0, reset_n = 1'b0, restart = 1'b0, tile_aligned = 1'b0;
  logic up = 1'b0, right = 1'b0, down = 1'b0, left = 1'b0;
  logic [3:0] wall_free = 4'b0000;
  direction_t dir, pending_dir;
  logic pending_valid, turn_strobe;
  int passed = 0, total = 0;

  always #5 clk = ~clk;

  queued_direction_controller #(.DEBOUNCE_CYCLES(DEB), .PENDING_TIMEOUT(TMO), .REVERSE_IMMEDIATE(1)) dut (
    .clk(clk), .reset_n(reset_n), .restart(restart), .up(up), .right(right), .down(down),
    .left(left), .tile_aligned(tile_aligned), .wall_free(wall_free), .dir(dir),
    .pending_dir(pending_dir), .pending_valid(pending_valid), .turn_strobe(turn_strobe)
  );

  // reference model: directions as 0=idle,1=up,2=right,3=down,4=left; wall bit = dir-1
  int mdir, mpdir, mtimer;
  bit mpv, mts;
  bit mlevel[4], mrise[4];
  bit mhist[4][DEB];

  function automatic int opp(input int d);
    return d == 0 ? 0 : ((d + 1) % 4) + 1;
  endfunction

  task automatic model_reset();
    mdir = 0; mpdir = 0; mpv = 0; mtimer = 0; mts = 0;
    for (int b = 0; b < 4; b++) begin
      mlevel[b] = 0; mrise[b] = 0;
      for (int k = 0; k < DEB; k++) mhist[b][k] = 0;
    end
  endtask

  task automatic model_clear();
    mpdir = 0; mpv = 0; mtimer = 0;
  endtask

  task automatic model_store(input int d);
    mpdir = d; mpv = 1; mtimer = TMO;
  endtask

  task automatic model_step();
    logic [3:0] raw;
    int p, c;
    bit press, all;
    raw = {left, down, right, up};
    p = mrise[2] ? 3 : mrise[0] ? 1 : mrise[3] ? 4 : mrise[1] ? 2 : 0;
    press = p != 0 && !(mdir != 0 && p == mdir);
    mts = 0;
    if (restart) begin
      mdir = 0; model_clear();
    end else if (press && ((mdir != 0 && p == opp(mdir)) || (mdir == 0 && wall_free[p-1]))) begin
      mdir = p; mts = 1; model_clear();
    end else if (tile_aligned) begin
      c = press ? p : (mpv ? mpdir : 0);
      if (c != 0 && wall_free[c-1]) begin
        mts = c != mdir; mdir = c; model_clear();
      end else begin
        if (mdir != 0 && !wall_free[mdir-1]) mdir = 0;
        if (press) model_store(p);
        else if (mpv) begin
          mtimer--;
          if (mtimer == 0) model_clear();
        end
      end
    end else if (press) model_store(p);
    // a level changes once the last DEB raw samples all disagree with it
    for (int b = 0; b < 4; b++) begin
      for (int k = DEB - 1; k > 0; k--) mhist[b][k] = mhist[b][k-1];
      mhist[b][0] = raw[b];
      all = 1;
      for (int k = 0; k < DEB; k++) if (mhist[b][k] == mlevel[b]) all = 0;
      mrise[b] = all && raw[b];
      if (all) mlevel[b] = raw[b];
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      model_step();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_outs(input string name, input direction_t d, input direction_t pd, input bit pv, input bit ts);
    check({name, ".dir"}, int'(dir), int'(d));
    check({name, ".pending_dir"}, int'(pending_dir), int'(pd));
    check({name, ".pending_valid"}, int'(pending_valid), int'(pv));
    check({name, ".turn_strobe"}, int'(turn_strobe), int'(ts));
  endtask

  task automatic set_btn(input logic [3:0] b);
    {left, down, right, up} = b;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #2;
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] btn;
    logic [3:0] wall;
    direction_t d;
    direction_t pd;
    logic pv;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [3:0] btn;
    vecs = '{
      '{4'b1101, 4'b1111, DOWN,  IDLE, 1'b0},
      '{4'b1001, 4'b1111, UP,    IDLE, 1'b0},
      '{4'b1010, 4'b1111, LEFT,  IDLE, 1'b0},
      '{4'b0010, 4'b1111, RIGHT, IDLE, 1'b0},
      '{4'b0110, 4'b0010, IDLE,  DOWN, 1'b1},
      '{4'b0001, 4'b0000, IDLE,  UP,   1'b1},
      '{4'b1111, 4'b1011, IDLE,  DOWN, 1'b1},
      '{4'b1100, 4'b0100, DOWN,  IDLE, 1'b0}
    };
    model_reset();
    #3;
    check_outs("reset", IDLE, IDLE, 1'b0, 1'b0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // bounce: right 1,0,1 then held
    wall_free = 4'b0010;
    right = 1'b1; tick(1);
    right = 1'b0; tick(1);
    right = 1'b1; tick(4);
    check_outs("bounce_wait", IDLE, IDLE, 1'b0, 1'b0);
    tick(1);
    check_outs("bounce_turn", RIGHT, IDLE, 1'b0, 1'b1);
    tick(1);
    check_outs("bounce_after", RIGHT, IDLE, 1'b0, 1'b0);

    // pre-turn buffered then applied at alignment
    up = 1'b1; tick(DEB + 1);
    check_outs("preturn_buf", RIGHT, UP, 1'b1, 1'b0);
    tile_aligned = 1'b1; wall_free = 4'b0011; tick(1); tile_aligned = 1'b0;
    check_outs("preturn_apply", UP, IDLE, 1'b0, 1'b1);

    // timeout of a blocked pending request
    set_btn(4'b0000); tick(1); do_reset();
    wall_free = 4'b0010;
    right = 1'b1; tick(DEB + 1);
    check("tmo_start.dir", int'(dir), int'(RIGHT));
    right = 1'b0; tick(DEB + 1);
    up = 1'b1; tick(DEB + 1);
    check_outs("tmo_buf", RIGHT, UP, 1'b1, 1'b0);
    for (int s = 1; s <= TMO; s++) begin
      tile_aligned = 1'b1; tick(1); tile_aligned = 1'b0;
      check_outs($sformatf("tmo_strobe%0d", s), RIGHT, s < TMO ? UP : IDLE, s < TMO, 1'b0);
      tick(2);
    end

    // immediate reverse, then stop at a wall
    up = 1'b0; tick(DEB + 1);
    left = 1'b1; tick(DEB);
    check("rev_wait.dir", int'(dir), int'(RIGHT));
    tick(1);
    check_outs("rev_turn", LEFT, IDLE, 1'b0, 1'b1);
    wall_free = 4'b0000; tile_aligned = 1'b1; tick(1); tile_aligned = 1'b0;
    check_outs("wall_stop", IDLE, IDLE, 1'b0, 1'b0);

    // priority and idle-start table
    foreach (vecs[i]) begin
      set_btn(4'b0000); tick(1); do_reset();
      wall_free = vecs[i].wall;
      set_btn(vecs[i].btn);
      tick(DEB + 1);
      check_outs($sformatf("prio%0d", i), vecs[i].d, vecs[i].pd, vecs[i].pv, vecs[i].d != IDLE);
    end

    // asynchronous reset mid-pending and mid-debounce
    set_btn(4'b0000); tick(1); do_reset();
    wall_free = 4'b0000;
    up = 1'b1; tick(DEB + 1);
    check("arst_pre.pending_valid", int'(pending_valid), 1);
    right = 1'b1; tick(2);
    reset_n = 1'b0; model_reset(); #1;
    check_outs("arst", IDLE, IDLE, 1'b0, 1'b0);
    set_btn(4'b0000); reset_n = 1'b1;
    tick(1);

    // restart with right held
    wall_free = 4'b0010;
    right = 1'b1; tick(DEB + 1);
    check("rst_pre.dir", int'(dir), int'(RIGHT));
    restart = 1'b1; tick(1); restart = 1'b0;
    check_outs("restart", IDLE, IDLE, 1'b0, 1'b0);
    tick(10);
    check_outs("restart_held", IDLE, IDLE, 1'b0, 1'b0);
    right = 1'b0; tick(DEB + 1);
    right = 1'b1; tick(DEB + 1);
    check_outs("restart_repress", RIGHT, IDLE, 1'b0, 1'b1);

    // randomized run against the reference model
    set_btn(4'b0000); tile_aligned = 1'b0; tick(1); do_reset();
    btn = 4'b0000;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 11) == 0) btn[b] = ~btn[b];
      set_btn(btn);
      tile_aligned = $urandom_range(0, 3) == 0;
      wall_free = 4'($urandom);
      restart = $urandom_range(0, 149) == 0;
      tick(1);
      check("rnd.dir", int'(dir), mdir);
      check("rnd.pending_dir", int'(pending_dir), mpdir);
      check("rnd.pending_valid", int'(pending_valid), int'(mpv));
      check("rnd.turn_strobe", int'(turn_strobe), int'(mts));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
